// File: rtl/pipe_pkg.sv
// pipe_pkg: shared sequencer states and constants for the pipeline flow controller
package pipe_pkg;
  typedef enum logic [1:0] {BOOT, RUN, LU_STALL, IMEM_WAIT} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;
  localparam int PC_INC = 4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != '1) q <= q + WIDTH'(1);
endmodule

// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: turns load-use stall and redirect requests into PC, enable and flush strobes
module pipe_flow_ctrl
  import pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  lu_stall_req,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  imem_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  ifid_we,
  output logic                  ifid_flush,
  output logic                  idex_we,
  output logic                  idex_flush,
  output logic                  exmem_bubble,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt
);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] pc_n;
  logic lu_mask, stall, stall_inc, flush_inc;
  assign imem_addr = pc;
  assign stall = lu_stall_req && !lu_mask;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      lu_mask <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n & ~DATA_WIDTH'(3);
      lu_mask <= state != BOOT && stall;
    end
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    imem_req     = 1'b0;
    ifid_we      = 1'b0;
    ifid_flush   = 1'b0;
    idex_we      = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (state == BOOT) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_n    = RUN;
    end else begin
      imem_req = 1'b1;
      // a stall during an imem wait keeps waiting; ID already holds a bubble
      if (stall) begin
        exmem_bubble = 1'b1;
        stall_inc    = 1'b1;
        ifid_flush   = state == IMEM_WAIT;
        state_n      = state == IMEM_WAIT ? IMEM_WAIT : LU_STALL;
      end else if (redirect_valid) begin
        pc_n       = redirect_pc;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
        state_n    = RUN;
      end else if (!imem_ready) begin
        ifid_flush = 1'b1;
        idex_we    = 1'b1;
        state_n    = IMEM_WAIT;
      end else begin
        pc_n    = pc + DATA_WIDTH'(PC_INC);
        ifid_we = 1'b1;
        idex_we = 1'b1;
        state_n = RUN;
      end
    end
    if (!rstn) begin
      imem_req     = 1'b0;
      ifid_we      = 1'b0;
      ifid_flush   = 1'b0;
      idex_we      = 1'b0;
      idex_flush   = 1'b0;
      exmem_bubble = 1'b0;
    end
  end
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk(clk), .rstn(rstn), .inc(stall_inc), .clr(1'b0), .q(stall_cnt)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk(clk), .rstn(rstn), .inc(flush_inc), .clr(1'b0), .q(flush_cnt)
  );
endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb_pipe_flow_ctrl: directed and random checks of pipe_flow_ctrl against a rule-level model
module tb_pipe_flow_ctrl;
  logic clk = 1'b0, rstn = 1'b1, lu = 1'b0, rv = 1'b0, rdy = 1'b1;
  logic [31:0] rpc = '0;
  logic [31:0] imem_addr, pc, s_imem_addr, s_pc;
  logic imem_req, ifid_we, ifid_flush, idex_we, idex_flush, exmem_bubble;
  logic s_imem_req, s_ifid_we, s_ifid_flush, s_idex_we, s_idex_flush, s_exmem_bubble;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0] s_stall_cnt, s_flush_cnt;
  int checks = 0, failures = 0;
  logic m_boot, m_wait, m_mask;
  logic [31:0] m_pc;
  int m_stalls, m_flushes;
  always #5 clk = ~clk;
  pipe_flow_ctrl u_dut (
    .clk(clk), .rstn(rstn), .lu_stall_req(lu), .redirect_valid(rv), .redirect_pc(rpc),
    .imem_ready(rdy), .imem_addr(imem_addr), .imem_req(imem_req), .pc(pc),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_flush(idex_flush),
    .exmem_bubble(exmem_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  pipe_flow_ctrl #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rstn(rstn), .lu_stall_req(lu), .redirect_valid(rv), .redirect_pc(rpc),
    .imem_ready(rdy), .imem_addr(s_imem_addr), .imem_req(s_imem_req), .pc(s_pc),
    .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush), .idex_we(s_idex_we), .idex_flush(s_idex_flush),
    .exmem_bubble(s_exmem_bubble), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int sat(input int n, input int mx);
    return n > mx ? mx : n;
  endfunction
  task automatic model_reset();
    m_boot = 1'b1; m_wait = 1'b0; m_mask = 1'b0; m_pc = '0; m_stalls = 0; m_flushes = 0;
  endtask
  task automatic check_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_ifid_we", ifid_we, 1'b0);
    chk("rst_ifid_flush", ifid_flush, 1'b0);
    chk("rst_idex_we", idex_we, 1'b0);
    chk("rst_idex_flush", idex_flush, 1'b0);
    chk("rst_bubble", exmem_bubble, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    chk("rst_flush_cnt", flush_cnt, 32'h0);
    chk("rst_s_stall_cnt", s_stall_cnt, 32'h0);
  endtask
  task automatic step(input logic l, input logic r, input logic [31:0] t, input logic y);
    logic st, rd, wt, ad;
    lu = l; rv = r; rpc = t; rdy = y;
    #1;
    st = !m_boot && l && !m_mask;
    rd = !m_boot && !st && r;
    wt = !m_boot && !st && !rd && !y;
    ad = !m_boot && !st && !rd && y;
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_req", imem_req, !m_boot);
    chk("ifid_we", ifid_we, ad);
    chk("ifid_flush", ifid_flush, m_boot || rd || wt || (st && m_wait));
    chk("idex_we", idex_we, ad || wt);
    chk("idex_flush", idex_flush, m_boot || rd);
    chk("exmem_bubble", exmem_bubble, st);
    chk("stall_cnt", stall_cnt, sat(m_stalls, 65535));
    chk("flush_cnt", flush_cnt, sat(m_flushes, 65535));
    chk("s_stall_cnt", s_stall_cnt, sat(m_stalls, 3));
    chk("s_flush_cnt", s_flush_cnt, sat(m_flushes, 3));
    @(posedge clk);
    if (st) m_stalls++;
    if (rd) begin m_pc = t & ~32'h3; m_flushes++; m_wait = 1'b0; end
    if (wt) m_wait = 1'b1;
    if (ad) begin m_pc = m_pc + 32'd4; m_wait = 1'b0; end
    m_mask = st;
    m_boot = 1'b0;
    @(negedge clk);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b1);
  endtask
  initial begin
    #2 rstn = 1'b0;
    @(negedge clk);
    #1 check_reset();
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    repeat (3) idle();
    chk("boot_pc8", pc, 32'h8);
    for (int i = 0; i < 20 && m_pc != 32'h10; i++) idle();
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("lu_hold", pc, 32'h10);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("lu_once", pc, 32'h14);
    chk("lu_cnt", stall_cnt, 32'h1);
    for (int i = 0; i < 20 && m_pc != 32'h20; i++) idle();
    step(1'b0, 1'b1, 32'h101, 1'b1);
    chk("redir_pc", pc, 32'h100);
    chk("redir_cnt", flush_cnt, 32'h1);
    step(1'b1, 1'b1, 32'h300, 1'b1);
    chk("both_hold", pc, 32'h100);
    step(1'b0, 1'b1, 32'h300, 1'b1);
    chk("both_redir", pc, 32'h300);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wait_addr", imem_addr, 32'h40);
    idle();
    chk("wait_exit", pc, 32'h44);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h200, 1'b0);
    chk("wait_redir", imem_addr, 32'h200);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    idle();
    repeat (5) begin step(1'b1, 1'b0, 32'h0, 1'b1); idle(); end
    chk("sat_stall", s_stall_cnt, 32'h3);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    idle();
    chk("pc_wrap", pc, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    lu = 1'b1; rv = 1'b1; rpc = 32'h500; rstn = 1'b0;
    #1 check_reset();
    @(negedge clk);
    check_reset();
    rstn = 1'b1;
    model_reset();
    repeat (400)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 3) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
